ext_pipe_unit: RTL and testbench

- Parametrised, pipelined immediate-extension unit for the datapath, handling IN_W to OUT_W extension.
- Generalises the fixed 16->32 and 1->32 sign extenders.
- Provides four run-time modes: sign, zero, sign-then-shift-left-2 (branch offset), upper (LUI-style).
- Registered output with valid/ready handshake and a one-entry skid buffer, so a stalled consumer never drops or reorders operands.

---
 rtl/ext_pipe_unit.sv | 129 ++++++++++++
 tb/tb_ext_pipe_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_pipe_unit.sv
// Pipelined immediate extender (sign / zero / sign+shl2 / upper) with valid/ready and a one-entry skid buffer.
// Optional EXT_COUNT_EN macro adds a 16-bit xfer_count output counting completed output transfers.
module ext_pipe_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef EXT_COUNT_EN
    output logic [OUT_W-1:0] out_data,
    output logic [15:0]      xfer_count
`else
    output logic [OUT_W-1:0] out_data
`endif
);

    localparam int PAD_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] ext_val;
    logic             accept;
    logic             xfer;

    always_comb begin
        sign_ext = {{PAD_W{in_data[IN_W-1]}}, in_data};
        ext_val  = sign_ext;
        case (in_mode)
            2'b00:   ext_val = sign_ext;
            2'b01:   ext_val = {{PAD_W{1'b0}}, in_data};
            2'b10:   ext_val = {sign_ext[OUT_W-3:0], 2'b00};
            default: ext_val = {in_data, {PAD_W{1'b0}}};
        endcase
    end

    assign accept = in_valid && in_ready_q;
    assign xfer   = out_valid_q && out_ready;

    // The skid only fills when the output register is busy and not draining;
    // on a drain from FULL the skid entry slides forward so order is kept.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    out_data_d = ext_val;
                    state_d    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && xfer) begin
                    out_data_d = ext_val;
                end else if (accept) begin
                    skid_d  = ext_val;
                    state_d = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    out_data_d = skid_q;
                    state_d    = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            out_data_q  <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef EXT_COUNT_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer ? xfer_count_q + 16'd1 : xfer_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Self-checking bench for ext_pipe_unit: table-driven extension vectors on IN_W=16 and IN_W=1
// instances, plus hand-written backpressure, streaming and reset-while-full sequences.
module tb_ext_pipe_unit;

    typedef struct {
        string       name;
        bit          sel;
        logic [15:0] data;
        logic [1:0]  mode;
        logic [31:0] expected;
    } vec_t;

    logic        clk;
    logic        reset_n;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_data16;
    logic [1:0]  in_mode16;
    logic [31:0] out_data16;

    logic        in_valid1, in_ready1, out_valid1, out_ready1;
    logic [0:0]  in_data1;
    logic [1:0]  in_mode1;
    logic [31:0] out_data1;

`ifdef EXT_COUNT_EN
    logic [15:0] xfer_count16, xfer_count1;
`endif

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    ext_pipe_unit #(.IN_W(16), .OUT_W(32)) dut16 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_data   (in_data16),
        .in_mode   (in_mode16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
`ifdef EXT_COUNT_EN
        .out_data  (out_data16),
        .xfer_count(xfer_count16)
`else
        .out_data  (out_data16)
`endif
    );

    ext_pipe_unit #(.IN_W(1), .OUT_W(32)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_data   (in_data1),
        .in_mode   (in_mode1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
`ifdef EXT_COUNT_EN
        .out_data  (out_data1),
        .xfer_count(xfer_count1)
`else
        .out_data  (out_data1)
`endif
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input string name, input bit sel, input logic [15:0] data,
                          input logic [1:0] mode, input logic [31:0] expected);
        vec_t v;
        v.name     = name;
        v.sel      = sel;
        v.data     = data;
        v.mode     = mode;
        v.expected = expected;
        vecs.push_back(v);
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One accept with the consumer ready: result must appear right after the accepting edge,
    // then drain on the following edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        if (v.sel) begin
            in_valid1 = 1'b1;
            in_data1  = v.data[0];
            in_mode1  = v.mode;
        end else begin
            in_valid16 = 1'b1;
            in_data16  = v.data;
            in_mode16  = v.mode;
        end
        @(posedge clk);
        #1;
        in_valid1  = 1'b0;
        in_valid16 = 1'b0;
        checkOutput({v.name, "_valid"}, {31'd0, v.sel ? out_valid1 : out_valid16}, 32'd1);
        checkOutput(v.name, v.sel ? out_data1 : out_data16, v.expected);
        @(posedge clk);
        #1;
        checkOutput({v.name, "_drained"}, {31'd0, v.sel ? out_valid1 : out_valid16}, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid16  = 1'b0;
        in_data16   = '0;
        in_mode16   = 2'b00;
        out_ready16 = 1'b1;
        in_valid1   = 1'b0;
        in_data1    = '0;
        in_mode1    = 2'b00;
        out_ready1  = 1'b1;

        addVec("sign_654C",   1'b0, 16'h654C, 2'b00, 32'h0000654C);
        addVec("sign_ACCC",   1'b0, 16'hACCC, 2'b00, 32'hFFFFACCC);
        addVec("zero_ACCC",   1'b0, 16'hACCC, 2'b01, 32'h0000ACCC);
        addVec("zero_FFFF",   1'b0, 16'hFFFF, 2'b01, 32'h0000FFFF);
        addVec("shl2_ACCC",   1'b0, 16'hACCC, 2'b10, 32'hFFFEB330);
        addVec("shl2_0001",   1'b0, 16'h0001, 2'b10, 32'h00000004);
        addVec("shl2_8000",   1'b0, 16'h8000, 2'b10, 32'hFFFE0000);
        addVec("upper_1234",  1'b0, 16'h1234, 2'b11, 32'h12340000);
        addVec("upper_8001",  1'b0, 16'h8001, 2'b11, 32'h80010000);
        addVec("w1_sign_1",   1'b1, 16'h0001, 2'b00, 32'hFFFFFFFF);
        addVec("w1_sign_0",   1'b1, 16'h0000, 2'b00, 32'h00000000);
        addVec("w1_upper_1",  1'b1, 16'h0001, 2'b11, 32'h80000000);
        addVec("w1_zero_1",   1'b1, 16'h0001, 2'b01, 32'h00000001);
        addVec("w1_shl2_1",   1'b1, 16'h0001, 2'b10, 32'hFFFFFFFC);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state of both instances.
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid16}, 32'd0);
        checkOutput("rst_out_data",  out_data16, 32'd0);
        checkOutput("rst_in_ready",  {31'd0, in_ready16}, 32'd1);
        checkOutput("rst_w1_in_ready", {31'd0, in_ready1}, 32'd1);
`ifdef EXT_COUNT_EN
        checkOutput("rst_count", {16'd0, xfer_count16}, 32'd0);
`endif

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Backpressure: two accepts fill out reg + skid, third is held off.
        resetDut();
        out_ready16 = 1'b0;
        in_mode16   = 2'b01;
        in_valid16  = 1'b1;
        in_data16   = 16'h0001;
        @(posedge clk); #1;
        checkOutput("bp_ready_after_1", {31'd0, in_ready16}, 32'd1);
        checkOutput("bp_data_after_1",  out_data16, 32'h00000001);
        @(negedge clk);
        in_data16 = 16'h0002;
        @(posedge clk); #1;
        checkOutput("bp_ready_after_2", {31'd0, in_ready16}, 32'd0);
        @(negedge clk);
        in_data16 = 16'h0003;
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("bp_hold_ready", {31'd0, in_ready16}, 32'd0);
            checkOutput("bp_hold_data",  out_data16, 32'h00000001);
            checkOutput("bp_hold_valid", {31'd0, out_valid16}, 32'd1);
        end
        @(negedge clk);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_out_2", out_data16, 32'h00000002);
        checkOutput("bp_ready_reopen", {31'd0, in_ready16}, 32'd1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checkOutput("bp_out_3", out_data16, 32'h00000003);
        @(posedge clk); #1;
        checkOutput("bp_drained", {31'd0, out_valid16}, 32'd0);
`ifdef EXT_COUNT_EN
        checkOutput("bp_count", {16'd0, xfer_count16}, 32'd3);
`endif

        // Streaming: one result per cycle, in order, no bubbles.
        resetDut();
        out_ready16 = 1'b1;
        in_mode16   = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid16 = 1'b1;
            in_data16  = 16'(i + 1);
            @(posedge clk); #1;
            checkOutput("stream_valid", {31'd0, out_valid16}, 32'd1);
            checkOutput("stream_data",  out_data16, 32'(i + 1));
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        @(posedge clk); #1;
        checkOutput("stream_drained", {31'd0, out_valid16}, 32'd0);
`ifdef EXT_COUNT_EN
        checkOutput("stream_count", {16'd0, xfer_count16}, 32'd8);
`endif

        // Reset asserted while FULL must clear everything immediately.
        @(negedge clk);
        out_ready16 = 1'b0;
        in_mode16   = 2'b01;
        in_valid16  = 1'b1;
        in_data16   = 16'h00AA;
        @(posedge clk);
        @(negedge clk);
        in_data16 = 16'h00BB;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        checkOutput("full_ready", {31'd0, in_ready16}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rstfull_out_valid", {31'd0, out_valid16}, 32'd0);
        checkOutput("rstfull_in_ready",  {31'd0, in_ready16}, 32'd1);
        checkOutput("rstfull_out_data",  out_data16, 32'd0);
`ifdef EXT_COUNT_EN
        checkOutput("rstfull_count", {16'd0, xfer_count16}, 32'd0);
`endif
        @(negedge clk);
        reset_n     = 1'b1;
        out_ready16 = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("rstfull_no_stale", {31'd0, out_valid16}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
